// File: rtl/node_processing_mem_portb_arbiter.sv
// node_processing_mem_portb_arbiter
//
// Shares port B (s2) of a node's dual-port processing memory between two
// Avalon-MM requesters. Master 0 is the network receive DMA and master 1 is
// the send/debug path.
//
// Arbitration is round-robin. A master may also hold the grant for a short
// atomic sequence by asserting lock, and that hold is bounded by LOCK_MAX
// transfers. Port B registers its address and returns data unregistered, so
// every accepted read returns its data exactly one cycle later.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   reset_req            memory clock-enable kill; blocks all new transfers
//   m0_*, m1_*           Avalon-MM slave ports, one per requester
//                        (address, read, write, writedata, byteenable, lock,
//                         waitrequest, readdata, readdatavalid)
//   mem_*2               memory s2 interface (address, chipselect, write,
//                        writedata, byteenable, clken, readdata)
//   rw_err               sticky flag: some master asserted read and write together
module node_processing_mem_portb_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address2,
  output logic              mem_chipselect2,
  output logic              mem_write2,
  output logic [DATA_W-1:0] mem_writedata2,
  output logic [BE_W-1:0]   mem_byteenable2,
  output logic              mem_clken2,
  input  logic [DATA_W-1:0] mem_readdata2,
  output logic              rw_err
);

  localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

  logic       rr_ptr;
  logic       lock_valid;
  logic       lock_owner;
  logic [7:0] lock_cnt;
  logic       rd_pend;
  logic       rd_tag;

  logic req0;
  logic req1;
  logic grant_valid;
  logic winner;
  logic win_write;
  logic win_lock;
  logic rd_accept;
  logic [7:0] lock_cnt_inc;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // The winner is chosen purely from the registered arbitration state and the
  // current requests. While locked, only the owner is eligible. Reset and
  // reset_req both block every new transfer.
  always_comb begin
    grant_valid = 1'b0;
    winner      = 1'b0;
    if (!reset && !reset_req) begin
      if (lock_valid) begin
        winner      = lock_owner;
        grant_valid = lock_owner ? req1 : req0;
      end else if (req0 && req1) begin
        winner      = rr_ptr;
        grant_valid = 1'b1;
      end else if (req0) begin
        winner      = 1'b0;
        grant_valid = 1'b1;
      end else if (req1) begin
        winner      = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

  // A request with both read and write asserted is handled as a write.
  assign win_write    = winner ? m1_write : m0_write;
  assign win_lock     = winner ? m1_lock  : m0_lock;
  assign rd_accept    = grant_valid & ~win_write;
  assign lock_cnt_inc = lock_cnt + 8'd1;

  assign m0_waitrequest = ~(grant_valid & ~winner);
  assign m1_waitrequest = ~(grant_valid &  winner);

  assign mem_chipselect2 = grant_valid;
  assign mem_write2      = grant_valid & win_write;
  assign mem_address2    = grant_valid ? (winner ? m1_address    : m0_address)    : '0;
  assign mem_writedata2  = grant_valid ? (winner ? m1_writedata  : m0_writedata)  : '0;
  assign mem_byteenable2 = grant_valid ? (winner ? m1_byteenable : m0_byteenable) : '0;
  assign mem_clken2      = 1'b1;

  // Read data is returned the cycle after acceptance. Reset in that return
  // cycle suppresses the strobe, and reset_req does not.
  assign m0_readdatavalid = rd_pend & ~rd_tag & ~reset;
  assign m1_readdatavalid = rd_pend &  rd_tag & ~reset;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata2 : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata2 : '0;

  // Arbitration state, lock bookkeeping and the read-return pipeline stage.
  // While reset_req is high, only the read return keeps moving.
  // A locked owner that stops requesting, drops lock, or reaches LOCK_MAX
  // releases the lock. The pointer then favours the other master.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= 8'd0;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
      rw_err     <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) begin
        rd_tag <= winner;
      end
      if (!reset_req) begin
        if ((m0_read && m0_write) || (m1_read && m1_write)) begin
          rw_err <= 1'b1;
        end
        if (lock_valid) begin
          if (grant_valid && win_lock && (lock_cnt_inc < LOCK_LIMIT)) begin
            lock_cnt <= lock_cnt_inc;
          end else begin
            lock_valid <= 1'b0;
            lock_cnt   <= 8'd0;
            rr_ptr     <= ~lock_owner;
          end
        end else if (grant_valid) begin
          rr_ptr <= ~winner;
          if (win_lock && (LOCK_MAX > 1)) begin
            lock_valid <= 1'b1;
            lock_owner <= winner;
            lock_cnt   <= 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_node_processing_mem_portb_arbiter.sv
// tb_node_processing_mem_portb_arbiter
//
// Directed scenarios followed by randomized traffic for the port-B arbiter.
// A behavioural model tracks the grant, lock budget and expected memory
// contents. A simple port-B memory with a registered address sits behind the
// DUT.
//
// Ports: none (top-level bench).
module tb_node_processing_mem_portb_arbiter;

  localparam int LMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset_req;
  logic [14:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [15:0] m0_writedata, m1_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable;
  logic        m0_lock, m1_lock;
  logic        m0_waitrequest, m1_waitrequest;
  logic [15:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] mem_address2;
  logic        mem_chipselect2, mem_write2, mem_clken2;
  logic [15:0] mem_writedata2;
  logic [1:0]  mem_byteenable2;
  logic [15:0] mem_readdata2;
  logic        rw_err;

  always #5 clk = ~clk;

  node_processing_mem_portb_arbiter #(
    .ADDR_W(15), .DATA_W(16), .BE_W(2), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address2(mem_address2), .mem_chipselect2(mem_chipselect2),
    .mem_write2(mem_write2), .mem_writedata2(mem_writedata2),
    .mem_byteenable2(mem_byteenable2), .mem_clken2(mem_clken2),
    .mem_readdata2(mem_readdata2), .rw_err(rw_err)
  );

  // Port-B memory: address registered under the memory clock enable, data out
  // unregistered. Contents are cleared on reset so the model can start clean.
  logic [15:0] mem [0:32767];
  logic [14:0] mem_areg;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32768; i++) mem[i] <= '0;
      mem_areg <= '0;
    end else if (!reset_req) begin
      if (mem_chipselect2 && mem_write2) begin
        if (mem_byteenable2[0]) mem[mem_address2][7:0]  <= mem_writedata2[7:0];
        if (mem_byteenable2[1]) mem[mem_address2][15:8] <= mem_writedata2[15:8];
      end
      mem_areg <= mem_address2;
    end
  end

  assign mem_readdata2 = mem[mem_areg];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [14:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        lk;
  } req_t;

  typedef struct {
    int          m;
    logic [15:0] d;
  } ret_t;

  // Behavioural reference state.
  // owner = -1 means unlocked. nlock counts transfers in the current lock.
  int          rr;
  int          owner;
  int          nlock;
  int          cur_win;
  bit          err;
  ret_t        retq[$];
  logic [15:0] sb [0:32767];

  int vectors = 0;
  int miscompares = 0;

  int   k;
  int   m0cnt;
  int   streak;
  bit   pat [12];
  req_t idle_r;
  req_t q0;
  req_t q1;

  function automatic req_t mk(input logic rd, input logic wr, input logic [14:0] a,
                              input logic [15:0] d, input logic [1:0] be, input logic lk);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wd = d; r.be = be; r.lk = lk;
    return r;
  endfunction

  function automatic req_t rnd_req();
    int op;
    logic [14:0] a;
    op = $urandom_range(0, 2);
    a  = 15'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) a = a | 15'h7FF0;
    return mk(op == 1, op == 2, a, 16'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Predicts this cycle's grant and outputs from the model, then compares
  // them with every DUT output.
  task automatic checkOutput();
    bit          rq0, rq1, ev0, ev1, ewr;
    int          win;
    logic [15:0] ed0, ed1, ewd;
    logic [14:0] ea;
    logic [1:0]  ebe;
    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    win = -1;
    if (!reset && !reset_req) begin
      if (owner >= 0) begin
        if ((owner == 0) ? rq0 : rq1) win = owner;
      end else if (rq0 && rq1) win = rr;
      else if (rq0) win = 0;
      else if (rq1) win = 1;
    end
    cur_win = win;
    ea = '0; ewd = '0; ebe = '0; ewr = 1'b0;
    if (win == 0) begin ea = m0_address; ewd = m0_writedata; ebe = m0_byteenable; ewr = m0_write; end
    if (win == 1) begin ea = m1_address; ewd = m1_writedata; ebe = m1_byteenable; ewr = m1_write; end
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (retq.size() > 0 && !reset) begin
      if (retq[0].m == 0) begin ev0 = 1'b1; ed0 = retq[0].d; end
      else begin ev1 = 1'b1; ed1 = retq[0].d; end
    end
    chk("m0_waitrequest", m0_waitrequest, win != 0);
    chk("m1_waitrequest", m1_waitrequest, win != 1);
    chk("mem_chipselect2", mem_chipselect2, win >= 0);
    chk("mem_write2", mem_write2, ewr);
    chk("mem_address2", mem_address2, ea);
    chk("mem_writedata2", mem_writedata2, ewd);
    chk("mem_byteenable2", mem_byteenable2, ebe);
    chk("mem_clken2", mem_clken2, 1);
    chk("m0_readdatavalid", m0_readdatavalid, ev0);
    chk("m1_readdatavalid", m1_readdatavalid, ev1);
    chk("m0_readdata", m0_readdata, ed0);
    chk("m1_readdata", m1_readdata, ed1);
    chk("rw_err", rw_err, err);
  endtask

  // Advances the model across the coming clock edge.
  task automatic modelUpdate();
    bit          wr, lk;
    logic [14:0] a;
    logic [15:0] d, mask;
    ret_t        e;
    if (retq.size() > 0) void'(retq.pop_front());
    if (reset) begin
      rr = 0; owner = -1; nlock = 0; err = 1'b0; retq.delete();
      for (int i = 0; i < 32768; i++) sb[i] = '0;
      return;
    end
    if (reset_req) return;
    if ((m0_read && m0_write) || (m1_read && m1_write)) err = 1'b1;
    if (cur_win >= 0) begin
      wr   = (cur_win == 0) ? m0_write : m1_write;
      lk   = (cur_win == 0) ? m0_lock : m1_lock;
      a    = (cur_win == 0) ? m0_address : m1_address;
      d    = (cur_win == 0) ? m0_writedata : m1_writedata;
      mask = (cur_win == 0) ? {{8{m0_byteenable[1]}}, {8{m0_byteenable[0]}}}
                            : {{8{m1_byteenable[1]}}, {8{m1_byteenable[0]}}};
      if (wr) sb[a] = (sb[a] & ~mask) | (d & mask);
      else begin
        e.m = cur_win; e.d = sb[a];
        retq.push_back(e);
      end
    end else begin
      lk = 1'b0;
    end
    if (owner >= 0) begin
      if (cur_win == owner && lk) begin
        nlock++;
        if (nlock >= LMAX) begin rr = 1 - owner; owner = -1; nlock = 0; end
      end else begin
        rr = 1 - owner; owner = -1; nlock = 0;
      end
    end else if (cur_win >= 0) begin
      rr = 1 - cur_win;
      if (lk && LMAX > 1) begin owner = cur_win; nlock = 1; end
    end
  endtask

  task automatic applyStimulus(input req_t a0, input req_t a1, input bit rst, input bit rrq);
    @(negedge clk);
    reset = rst; reset_req = rrq;
    m0_read = a0.rd; m0_write = a0.wr; m0_address = a0.addr;
    m0_writedata = a0.wd; m0_byteenable = a0.be; m0_lock = a0.lk;
    m1_read = a1.rd; m1_write = a1.wr; m1_address = a1.addr;
    m1_writedata = a1.wd; m1_byteenable = a1.be; m1_lock = a1.lk;
    #1;
    checkOutput();
    modelUpdate();
  endtask

  initial begin
    idle_r = mk(0, 0, '0, '0, '0, 0);
    reset = 1'b1; reset_req = 1'b0;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0; m0_lock = 0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0; m1_lock = 0;
    rr = 0; owner = -1; nlock = 0; err = 1'b0; cur_win = -1;
    for (int i = 0; i < 32768; i++) sb[i] = '0;

    // Reset state
    applyStimulus(idle_r, idle_r, 1, 0);
    applyStimulus(idle_r, idle_r, 1, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_cs", mem_chipselect2, 0);
    chk("rst_clken", mem_clken2, 1);

    // Single master write then read-back
    applyStimulus(mk(0, 1, 15'h0010, 16'hBEEF, 2'b11, 0), idle_r, 0, 0);
    chk("t1_wr_wait", m0_waitrequest, 0);
    applyStimulus(mk(1, 0, 15'h0010, '0, 2'b11, 0), idle_r, 0, 0);
    chk("t1_rd_wait", m0_waitrequest, 0);
    applyStimulus(idle_r, idle_r, 0, 0);
    chk("t1_rdv", m0_readdatavalid, 1);
    chk("t1_rdata", m0_readdata, 16'hBEEF);
    chk("t1_m1_rdv", m1_readdatavalid, 0);

    // Contention from reset: alternating grants
    applyStimulus(idle_r, idle_r, 1, 0);
    applyStimulus(mk(0, 1, 15'h0100, 16'hA5A5, 2'b11, 0), idle_r, 0, 0);
    applyStimulus(idle_r, mk(0, 1, 15'h0200, 16'h5A5A, 2'b11, 0), 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mk(1, 0, 15'h0100, '0, 2'b11, 0), mk(1, 0, 15'h0200, '0, 2'b11, 0), 0, 0);
      chk("t2_alt_m0", m0_waitrequest, i % 2);
      if (i > 0) begin
        chk("t2_rdv0", m0_readdatavalid, i % 2);
        chk("t2_rdata", (i % 2) ? m0_readdata : m1_readdata, (i % 2) ? 16'hA5A5 : 16'h5A5A);
      end
    end

    // Lock: m1 writes four words with lock 1,1,1,0 while m0 keeps reading
    applyStimulus(mk(1, 0, 15'h0001, '0, 2'b11, 0), idle_r, 0, 0);
    k = 0;
    for (int c = 0; c < 12 && k < 4; c++) begin
      applyStimulus(mk(1, 0, 15'h0002, '0, 2'b11, 0),
                    mk(0, 1, 15'(k + 4), 16'(16'h1100 + k), 2'b11, k < 3), 0, 0);
      chk("t3_m1_grant", m1_waitrequest, 0);
      if (cur_win == 1) k++;
    end
    chk("t3_done", k, 4);
    applyStimulus(mk(1, 0, 15'h0002, '0, 2'b11, 0), mk(0, 1, 15'h0008, 16'h2222, 2'b11, 0), 0, 0);
    chk("t3_m0_next", m0_waitrequest, 0);

    // Lock limit: m0 locks for 10 transfers while m1 keeps reading
    applyStimulus(idle_r, mk(1, 0, 15'h0004, '0, 2'b11, 0), 0, 0);
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    m0cnt = 0;
    streak = 0;
    for (int i = 0; i < 14; i++) begin
      q0 = (m0cnt < 10) ? mk(0, 1, 15'(16'h0040 + m0cnt), 16'($urandom), 2'b11, 1) : idle_r;
      applyStimulus(q0, mk(1, 0, 15'h0004, '0, 2'b11, 0), 0, 0);
      if (i < 12) chk("t4_m0_grant", !m0_waitrequest, pat[i]);
      streak = m1_waitrequest ? streak + 1 : 0;
      chk("t4_m1_bound", streak <= LMAX, 1);
      if (cur_win == 0) m0cnt++;
    end

    // reset_req pulse during round-robin reads
    for (int i = 0; i < 7; i++) begin
      applyStimulus(mk(1, 0, 15'h0040, '0, 2'b11, 0), mk(1, 0, 15'h0005, '0, 2'b11, 0),
                    0, (i >= 3 && i <= 5));
      if (i >= 3 && i <= 5) begin
        chk("t5_cs", mem_chipselect2, 0);
        chk("t5_m0_wait", m0_waitrequest, 1);
        chk("t5_m1_wait", m1_waitrequest, 1);
      end
      if (i == 3) chk("t5_inflight", m0_readdatavalid, 1);
      if (i == 6) chk("t5_resume", m1_waitrequest, 0);
    end

    // Read+write together, then reset right after a read accept
    applyStimulus(mk(1, 1, 15'h0020, 16'h1234, 2'b11, 0), idle_r, 0, 0);
    chk("t6_as_write", mem_write2, 1);
    applyStimulus(idle_r, idle_r, 0, 0);
    chk("t6_rw_err", rw_err, 1);
    applyStimulus(mk(1, 0, 15'h0020, '0, 2'b11, 0), idle_r, 0, 0);
    applyStimulus(idle_r, idle_r, 1, 0);
    chk("t6_suppress", m0_readdatavalid, 0);
    applyStimulus(idle_r, idle_r, 1, 0);
    chk("t6_err_clr", rw_err, 0);
    applyStimulus(idle_r, idle_r, 0, 0);
    chk("t6_post_rdv", m0_readdatavalid, 0);
    chk("t6_post_cs", mem_chipselect2, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      q0 = rnd_req();
      q1 = rnd_req();
      applyStimulus(q0, q1, 0, $urandom_range(0, 19) == 0);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
